// File: rtl/fb_mem_arbiter_if.sv
// Frame-buffer arbiter bus: reader port, writer port and memory command port.
//
// Handshake: a requester raises req with addr/data valid in the same cycle;
// gnt is combinational and a transfer happens on exactly the cycles where
// req && gnt. A requester need not hold req while refused. rd_valid/rd_data
// is a one-cycle response pulse per accepted read, returned in accept order,
// with no back-pressure. mem_en is a one-cycle command strobe qualifying
// mem_we/mem_addr/mem_wdata.
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Single-port frame-buffer arbiter between the display reader and the
// processed-image writer. The reader wins during active video, except that a
// writer refused WR_MAX_WAIT consecutive cycles is forced through. The writer
// wins during blanking. Accepted transfers become a registered memory command
// one cycle later; reads come back in order MEM_LAT cycles after the command
// (MEM_LAT legal range 1..4).
module fb_mem_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int MEM_LAT     = 1,
  parameter int WR_MAX_WAIT = 15
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 disp_active,
  input  logic                 frame_start,
  fb_mem_arbiter_if.slave      bus,
  output logic [15:0]          force_cnt
);

  // A zero wait limit still needs a one-bit counter to compare against.
  localparam int WC_W = (WR_MAX_WAIT > 0) ? $clog2(WR_MAX_WAIT + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WR_MAX_WAIT);

  logic [WC_W-1:0]   wait_cnt;
  logic              wr_wins;
  logic              rd_gnt_c;
  logic              wr_gnt_c;
  logic              forced;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [MEM_LAT-1:0] rd_pipe;

  // Grant decision: at most one grant per cycle, none while in reset.
  always_comb begin
    wr_wins  = !bus.rd_req || !disp_active || (wait_cnt == WC_MAX);
    wr_gnt_c = !rst && bus.wr_req && wr_wins;
    rd_gnt_c = !rst && bus.rd_req && !(bus.wr_req && wr_wins);
    // The writer beating a live reader in active video is only possible
    // through the starvation limit.
    forced   = wr_gnt_c && bus.rd_req && disp_active;
    accept   = rd_gnt_c || wr_gnt_c;
    acc_addr = wr_gnt_c ? bus.wr_addr : bus.rd_addr;
  end

  assign bus.rd_gnt = rd_gnt_c;
  assign bus.wr_gnt = wr_gnt_c;

  // Consecutive-refusal counter for the writer, saturating at the limit.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!bus.wr_req || wr_gnt_c) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WC_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Per-frame forced-grant count; frame_start reloads, counting a coincident force.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      force_cnt <= 16'h0000;
    end else if (frame_start) begin
      force_cnt <= forced ? 16'h0001 : 16'h0000;
    end else if (forced && (force_cnt != 16'hFFFF)) begin
      force_cnt <= force_cnt + 16'h0001;
    end
  end

  // Memory command register; address/data hold when idle, wdata holds on reads.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      bus.mem_en <= accept;
      bus.mem_we <= wr_gnt_c;
      if (accept) begin
        bus.mem_addr <= acc_addr;
      end
      if (wr_gnt_c) begin
        bus.mem_wdata <= bus.wr_data;
      end
    end
  end

  // Read tracker: one bit per issued read command, aligned to mem_rdata.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= bus.mem_en && !bus.mem_we;
      for (int i = 1; i < MEM_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  // Read return register: capture memory data as the tracked read emerges.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= {DATA_W{1'b0}};
    end else begin
      bus.rd_valid <= rd_pipe[MEM_LAT-1];
      if (rd_pipe[MEM_LAT-1]) begin
        bus.rd_data <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed timing checks plus randomized traffic
// against a cycle reference model and an in-order read scoreboard. A second
// instance with a zero wait limit forces on every contended cycle, which
// makes force_cnt saturation reachable in a short run.
module tb_fb_mem_arbiter;
  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int MEM_LAT     = 1;
  localparam int WR_MAX_WAIT = 15;

  // ---------------- clock / reset ----------------
  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic        rst, disp_active, frame_start;
  logic [15:0] force_cnt;
  logic        rst2, act2, fs2;
  logic [15:0] force_cnt2;
  logic        done2 = 1'b0;

  fb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  fb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  fb_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT),
                   .WR_MAX_WAIT(WR_MAX_WAIT)) u_dut (
    .pixel_clk(pixel_clk), .rst(rst), .disp_active(disp_active),
    .frame_start(frame_start), .bus(bus), .force_cnt(force_cnt)
  );

  fb_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2),
                   .WR_MAX_WAIT(0)) u_dut_sat (
    .pixel_clk(pixel_clk), .rst(rst2), .disp_active(act2),
    .frame_start(fs2), .bus(bus2), .force_cnt(force_cnt2)
  );
  assign bus2.mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // Power-on contents: 0x123 maps to 0xA5.
  function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h87;
  endfunction

  // ---------------- memory model (sync RAM, MEM_LAT read latency) ----------------
  logic [7:0] mem_m [1024];
  bit         mem_w [1024];
  logic [7:0] lat_q [MEM_LAT];
  always @(posedge pixel_clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_m[bus.mem_addr[9:0]] <= bus.mem_wdata;
      mem_w[bus.mem_addr[9:0]] <= 1'b1;
    end
    for (int i = MEM_LAT - 1; i > 0; i--) lat_q[i] <= lat_q[i-1];
    if (bus.mem_en && !bus.mem_we)
      lat_q[0] <= mem_w[bus.mem_addr[9:0]] ? mem_m[bus.mem_addr[9:0]]
                                           : init_val(bus.mem_addr);
  end
  assign bus.mem_rdata = lat_q[MEM_LAT-1];

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [7:0] ref_m [1024];
  bit         ref_w [1024];

  initial begin
    int refused = 0;
    int f_exp = 0;
    bit started = 0;
    bit prev_acc = 0, prev_we = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_wdata = '0;
    bit e_rd, e_wr, frc;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge pixel_clk);
      if (started) begin
        chk("force_cnt", force_cnt, f_exp);
        chk("mem_en", bus.mem_en, prev_acc);
        if (prev_acc) begin
          chk("mem_we", bus.mem_we, prev_we);
          chk("mem_addr", bus.mem_addr, prev_addr);
          if (prev_we) chk("mem_wdata", bus.mem_wdata, prev_wdata);
        end
      end
      e_rd = 0; e_wr = 0; frc = 0;
      if (!rst) begin
        if (bus.rd_req && bus.wr_req) begin
          if (!disp_active || refused == WR_MAX_WAIT) begin
            e_wr = 1;
            frc  = disp_active;
          end else begin
            e_rd = 1;
          end
        end else begin
          e_rd = bus.rd_req;
          e_wr = bus.wr_req;
        end
      end
      chk("rd_gnt", bus.rd_gnt, e_rd);
      chk("wr_gnt", bus.wr_gnt, e_wr);
      if (rst) begin
        refused = 0;
        f_exp   = 0;
        started = 1;
      end else begin
        if (bus.wr_req && !e_wr) refused = (refused < WR_MAX_WAIT) ? refused + 1 : WR_MAX_WAIT;
        else refused = 0;
        if (frame_start) f_exp = frc ? 1 : 0;
        else if (frc && f_exp < 65535) f_exp++;
      end
      prev_acc   = e_rd || e_wr;
      prev_we    = e_wr;
      prev_addr  = e_wr ? bus.wr_addr : bus.rd_addr;
      prev_wdata = bus.wr_data;
      if (e_wr) begin
        ref_m[bus.wr_addr[9:0]] = bus.wr_data;
        ref_w[bus.wr_addr[9:0]] = 1'b1;
      end
      if (e_rd) begin
        a = bus.rd_addr;
        exp_q.push_back(ref_w[a[9:0]] ? ref_m[a[9:0]] : init_val(a));
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge pixel_clk);
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", bus.rd_data, e);
        end
      end
      // Reads still in flight at a reset edge are dropped by the design.
      if (rst) exp_q.delete();
    end
  end

  // ---------------- saturation instance stimulus ----------------
  initial begin
    rst2 = 1; act2 = 1; fs2 = 0;
    bus2.rd_req = 0; bus2.wr_req = 0;
    bus2.rd_addr = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
    step(); step();
    rst2 = 0; bus2.rd_req = 1; bus2.wr_req = 1;
    step(); step(); step();
    bus2.rd_req = 0; bus2.wr_req = 0;
    @(negedge pixel_clk); chk("sat_force_cnt_3", force_cnt2, 32'd3);
    step(); fs2 = 1;
    step(); fs2 = 0;
    @(negedge pixel_clk); chk("sat_frame_clear", force_cnt2, 32'd0);
    step(); fs2 = 1; bus2.rd_req = 1; bus2.wr_req = 1;
    step(); fs2 = 0; bus2.rd_req = 0; bus2.wr_req = 0;
    @(negedge pixel_clk); chk("sat_frame_coincide", force_cnt2, 32'd1);
    step(); bus2.rd_req = 1; bus2.wr_req = 1;
    repeat (65540) step();
    bus2.rd_req = 0; bus2.wr_req = 0;
    @(negedge pixel_clk); chk("sat_force_cnt_max", force_cnt2, 32'hFFFF);
    step(); bus2.rd_req = 1; bus2.wr_req = 1;
    step(); bus2.rd_req = 0; bus2.wr_req = 0;
    @(negedge pixel_clk); chk("sat_force_cnt_hold", force_cnt2, 32'hFFFF);
    done2 = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int budget;
    rst = 1; disp_active = 0; frame_start = 0;
    bus.rd_req = 0; bus.wr_req = 0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
    step();

    // Reset with both requests high.
    bus.rd_req = 1; bus.wr_req = 1; disp_active = 1;
    repeat (3) begin
      @(negedge pixel_clk);
      chk("rst_rd_gnt", bus.rd_gnt, 32'd0);
      chk("rst_wr_gnt", bus.wr_gnt, 32'd0);
      step();
    end
    rst = 0; bus.rd_req = 0; bus.wr_req = 0;
    @(negedge pixel_clk);
    chk("rst_mem_en", bus.mem_en, 32'd0);
    chk("rst_rd_valid", bus.rd_valid, 32'd0);
    chk("rst_force_cnt", force_cnt, 32'd0);

    // Single read from 0x00123.
    step(); bus.rd_req = 1; bus.rd_addr = 19'h00123;
    @(negedge pixel_clk); chk("single_rd_gnt", bus.rd_gnt, 32'd1);
    step(); bus.rd_req = 0;
    @(negedge pixel_clk);
    chk("single_mem_en", bus.mem_en, 32'd1);
    chk("single_mem_we", bus.mem_we, 32'd0);
    chk("single_mem_addr", bus.mem_addr, 32'h00123);
    for (int k = 2; k <= 4; k++) begin
      step();
      @(negedge pixel_clk);
      chk($sformatf("single_rd_valid_t%0d", k), bus.rd_valid, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("single_rd_data", bus.rd_data, 32'hA5);
    end

    // Contention in active video: writer forced at T+15 and T+31.
    step(); frame_start = 1;
    step(); frame_start = 0;
    bus.rd_req = 1; bus.wr_req = 1; disp_active = 1;
    for (int i = 0; i < 40; i++) begin
      bus.rd_addr = 19'($urandom_range(0, 31));
      bus.wr_addr = 19'($urandom_range(0, 31));
      bus.wr_data = 8'($urandom_range(0, 255));
      @(negedge pixel_clk);
      chk($sformatf("active_wr_gnt_%0d", i), bus.wr_gnt, (i == 15 || i == 31) ? 32'd1 : 32'd0);
      chk($sformatf("active_rd_gnt_%0d", i), bus.rd_gnt, (i == 15 || i == 31) ? 32'd0 : 32'd1);
      step();
    end
    bus.rd_req = 0; bus.wr_req = 0;
    @(negedge pixel_clk); chk("active_force_cnt", force_cnt, 32'd2);

    // Contention in blanking: writer every cycle.
    step(); disp_active = 0; bus.rd_req = 1; bus.wr_req = 1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_addr = 19'($urandom_range(0, 31));
      bus.wr_data = 8'($urandom_range(0, 255));
      @(negedge pixel_clk);
      chk("blank_wr_gnt", bus.wr_gnt, 32'd1);
      chk("blank_rd_gnt", bus.rd_gnt, 32'd0);
      step();
    end
    bus.rd_req = 0; bus.wr_req = 0;
    @(negedge pixel_clk); chk("blank_force_cnt", force_cnt, 32'd2);

    // Reset with two reads in flight.
    repeat (4) step();
    disp_active = 1; bus.rd_req = 1; bus.rd_addr = 19'd3;
    @(negedge pixel_clk); chk("midrst_gnt_t0", bus.rd_gnt, 32'd1);
    step(); bus.rd_addr = 19'd4;
    @(negedge pixel_clk); chk("midrst_gnt_t1", bus.rd_gnt, 32'd1);
    step(); bus.rd_req = 0; rst = 1;
    step(); rst = 0;
    @(negedge pixel_clk);
    chk("midrst_rd_valid_t3", bus.rd_valid, 32'd0);
    chk("midrst_mem_en", bus.mem_en, 32'd0);
    step();
    @(negedge pixel_clk); chk("midrst_rd_valid_t4", bus.rd_valid, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      step();
      rst         = ($urandom_range(0, 199) == 0);
      frame_start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) disp_active = ~disp_active;
      bus.rd_req  = ($urandom_range(0, 9) < 8);
      bus.wr_req  = ($urandom_range(0, 9) < 6);
      bus.rd_addr = 19'($urandom_range(0, 31));
      bus.wr_addr = 19'($urandom_range(0, 31));
      bus.wr_data = 8'($urandom_range(0, 255));
    end
    step();
    rst = 0; frame_start = 0; bus.rd_req = 0; bus.wr_req = 0;
    repeat (10) step();
    chk("drain_exp_q_empty", exp_q.size(), 32'd0);

    budget = 0;
    while (!done2 && budget < 100000) begin
      step();
      budget++;
    end
    chk("sat_instance_done", done2, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
